// File: rtl/execute_stage_mdu.sv
// execute_stage_mdu: execute stage of the pipelined RV32 integer core.
// Single-cycle ALU, operand forwarding, an iterative RV32M multiply/divide
// unit and the EX/MEM pipeline register.
// Build option: define EXEC_MDU_DIV_EN to include the iterative divider.
// Without it, divide-class ops complete in one cycle with result 0.
// XLEN must be >= 8 and a power of two.
module execute_stage_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] ReadData1_E,
    input  logic [XLEN-1:0] ReadData2_E,
    input  logic [XLEN-1:0] ImmOut_E,
    input  logic [XLEN-1:0] ResultW,
    input  logic            ALUSrcE,
    input  logic            RegWriteE,
    input  logic            MemReadE,
    input  logic            MemWriteE,
    input  logic            MemtoRegE,
    input  logic            BranchE,
    input  logic            BNEE,
    input  logic            JMPE,
    input  logic [1:0]      ALUOpE,
    input  logic [6:0]      func7E,
    input  logic [2:0]      func3E,
    input  logic [4:0]      WriteAddr_E,
    input  logic [1:0]      ForwardA,
    input  logic [1:0]      ForwardB,
    output logic            mdu_busy,
    output logic            RegWriteM,
    output logic            MemReadM,
    output logic            MemWriteM,
    output logic            MemtoRegM,
    output logic            BranchM,
    output logic            BNEM,
    output logic            JMPM,
    output logic            ZeroM,
    output logic [4:0]      WriteAddr_M,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] ReadData2_M,
    output logic [XLEN-1:0] PCTargetM
);

    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } mdu_state_e;

    // ------------------------------------------------------------------
    // Forwarding
    // ------------------------------------------------------------------
    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] alu_b;

    // Select operand sources: register, writeback, memory-stage result, zero
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        case (ForwardA)
            2'b00:   fwd_a = ReadData1_E;
            2'b01:   fwd_a = ResultW;
            2'b10:   fwd_a = ALUResultM;
            default: fwd_a = '0;
        endcase
        case (ForwardB)
            2'b00:   fwd_b = ReadData2_E;
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = ALUResultM;
            default: fwd_b = '0;
        endcase
    end

    assign alu_b = ALUSrcE ? ImmOut_E : fwd_b;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic is_mop;
    logic mop_iter;

    assign is_mop = (ALUOpE == 2'b10) && (func7E == 7'b0000001);

`ifdef EXEC_MDU_DIV_EN
    assign mop_iter = is_mop;
`else
    // Divide-class ops (func3[2] set) fall through to the ALU and yield 0.
    assign mop_iter = is_mop & ~func3E[2];
`endif

    // ------------------------------------------------------------------
    // Single-cycle ALU
    // ------------------------------------------------------------------
    logic [XLEN-1:0] alu_result;

    // Combinational ALU; undecoded combinations (including M-ops) give 0
    always_comb begin
        alu_result = '0;
        if (ALUOpE == 2'b00) begin
            alu_result = fwd_a + alu_b;
        end else if (ALUOpE == 2'b01) begin
            alu_result = fwd_a - alu_b;
        end else if (func7E == 7'b0000000) begin
            case (func3E)
                3'b000:  alu_result = fwd_a + alu_b;
                3'b111:  alu_result = fwd_a & alu_b;
                3'b110:  alu_result = fwd_a | alu_b;
                3'b010:  alu_result = {{(XLEN-1){1'b0}}, ($signed(fwd_a) < $signed(alu_b))};
                default: alu_result = '0;
            endcase
        end else if ((func7E == 7'b0100000) && (func3E == 3'b000)) begin
            alu_result = fwd_a - alu_b;
        end
    end

    // ------------------------------------------------------------------
    // MDU operand preparation (signed ops work on magnitudes)
    // ------------------------------------------------------------------
    logic            a_signed_op;
    logic            b_signed_op;
    logic            neg_a;
    logic            neg_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;

    // MUL, MULH, MULHSU, DIV, REM treat A as signed; MULHSU leaves B unsigned
    always_comb begin
        a_signed_op = 1'b0;
        b_signed_op = 1'b0;
        case (func3E)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                a_signed_op = 1'b1;
                b_signed_op = 1'b1;
            end
            3'b010: a_signed_op = 1'b1;
            default: ;
        endcase
    end

    assign neg_a = a_signed_op & fwd_a[XLEN-1];
    assign neg_b = b_signed_op & fwd_b[XLEN-1];
    assign mag_a = neg_a ? -fwd_a : fwd_a;
    assign mag_b = neg_b ? -fwd_b : fwd_b;

    // ------------------------------------------------------------------
    // MDU datapath
    // acc_q holds {partial product high, multiplier} for multiply and
    // {remainder, dividend/quotient} for divide; both shift one bit a step.
    // ------------------------------------------------------------------
    mdu_state_e        state_q;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   b_q;
    logic [2:0]        op_q;
    logic              sign_a_q;
    logic              sign_b_q;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] step_d;

    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

`ifdef EXEC_MDU_DIV_EN
    logic            div0_q;
    logic [XLEN-1:0] div_trial;
    logic            div_ge;
    logic [2*XLEN-1:0] div_next;

    // Restoring step: the shifted remainder is XLEN+1 bits wide, the low
    // XLEN bits of the difference are all that survive a successful subtract.
    assign div_ge    = acc_q[2*XLEN-1:XLEN-1] >= {1'b0, b_q};
    assign div_trial = acc_q[2*XLEN-2:XLEN-1] - b_q;
    assign div_next  = div_ge ? {div_trial, acc_q[XLEN-2:0], 1'b1}
                              : {acc_q[2*XLEN-2:0], 1'b0};
    assign step_d    = op_q[2] ? div_next : mul_next;
`else
    assign step_d    = mul_next;
`endif

    // MDU sequencer: capture at issue, iterate XLEN steps, then one DONE cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
`ifdef EXEC_MDU_DIV_EN
            div0_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mop_iter && !stall) begin
                        acc_q    <= {{XLEN{1'b0}}, mag_a};
                        b_q      <= mag_b;
                        op_q     <= func3E;
                        sign_a_q <= neg_a;
                        sign_b_q <= neg_b;
`ifdef EXEC_MDU_DIV_EN
                        div0_q   <= (fwd_b == '0);
`endif
                        cnt_q    <= CW'(XLEN);
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_q <= step_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // MDU result with sign correction
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] mul_prod;
    logic [XLEN-1:0]   mdu_result;

    assign mul_prod = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;

    // Pick the product half or the corrected quotient/remainder
    always_comb begin
        mdu_result = '0;
        case (op_q)
            3'b000:                 mdu_result = mul_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: mdu_result = mul_prod[2*XLEN-1:XLEN];
`ifdef EXEC_MDU_DIV_EN
            // Divide by zero yields all ones; the remainder path already
            // returns the dividend because nothing is ever subtracted.
            3'b100, 3'b101: begin
                if (div0_q) begin
                    mdu_result = '1;
                end else if (sign_a_q ^ sign_b_q) begin
                    mdu_result = -acc_q[XLEN-1:0];
                end else begin
                    mdu_result = acc_q[XLEN-1:0];
                end
            end
            3'b110, 3'b111: mdu_result = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
`endif
            default:                mdu_result = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // EX/MEM register
    // ------------------------------------------------------------------
    logic [XLEN-1:0] ex_result;
    logic            bubble;

    assign ex_result = (state_q == ST_DONE) ? mdu_result : alu_result;

    // Gated by reset so the front end is never frozen while in reset
    assign mdu_busy = rst & (((state_q == ST_IDLE) & mop_iter & ~stall) | (state_q == ST_RUN));
    assign bubble   = mdu_busy | stall;

    // Pipeline register; a bubble clears every control bit and the zero flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteM   <= 1'b0;
            MemReadM    <= 1'b0;
            MemWriteM   <= 1'b0;
            MemtoRegM   <= 1'b0;
            BranchM     <= 1'b0;
            BNEM        <= 1'b0;
            JMPM        <= 1'b0;
            ZeroM       <= 1'b0;
            WriteAddr_M <= '0;
            ALUResultM  <= '0;
            ReadData2_M <= '0;
            PCTargetM   <= '0;
        end else begin
            RegWriteM   <= RegWriteE & ~bubble;
            MemReadM    <= MemReadE  & ~bubble;
            MemWriteM   <= MemWriteE & ~bubble;
            MemtoRegM   <= MemtoRegE & ~bubble;
            BranchM     <= BranchE   & ~bubble;
            BNEM        <= BNEE      & ~bubble;
            JMPM        <= JMPE      & ~bubble;
            ZeroM       <= (ex_result == '0) & ~bubble;
            WriteAddr_M <= WriteAddr_E;
            ALUResultM  <= ex_result;
            ReadData2_M <= fwd_b;
            PCTargetM   <= PCE + ImmOut_E;
        end
    end

endmodule

// File: tb/tb_execute_stage_mdu.sv
// Self-checking bench for execute_stage_mdu (XLEN = 32).
// Follows EXEC_MDU_DIV_EN to decide whether divide ops are iterative.
`timescale 1ns/1ps
module tb_execute_stage_mdu;
    localparam int XLEN = 32;
`ifdef EXEC_MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] PCE = '0, ReadData1_E = '0, ReadData2_E = '0, ImmOut_E = '0, ResultW = '0;
    logic        ALUSrcE = 1'b0, RegWriteE = 1'b0, MemReadE = 1'b0, MemWriteE = 1'b0;
    logic        MemtoRegE = 1'b0, BranchE = 1'b0, BNEE = 1'b0, JMPE = 1'b0;
    logic [1:0]  ALUOpE = '0;
    logic [6:0]  func7E = '0;
    logic [2:0]  func3E = '0;
    logic [4:0]  WriteAddr_E = '0;
    logic [1:0]  ForwardA = '0, ForwardB = '0;

    logic        mdu_busy, RegWriteM, MemReadM, MemWriteM, MemtoRegM, BranchM, BNEM, JMPM, ZeroM;
    logic [4:0]  WriteAddr_M;
    logic [31:0] ALUResultM, ReadData2_M, PCTargetM;

    logic [6:0]  ctrl_out;
    assign ctrl_out = {RegWriteM, MemReadM, MemWriteM, MemtoRegM, BranchM, BNEM, JMPM};

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_m = '0;   // model of the value currently held in ALUResultM

    execute_stage_mdu #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .PCE(PCE), .ReadData1_E(ReadData1_E), .ReadData2_E(ReadData2_E),
        .ImmOut_E(ImmOut_E), .ResultW(ResultW),
        .ALUSrcE(ALUSrcE), .RegWriteE(RegWriteE), .MemReadE(MemReadE), .MemWriteE(MemWriteE),
        .MemtoRegE(MemtoRegE), .BranchE(BranchE), .BNEE(BNEE), .JMPE(JMPE),
        .ALUOpE(ALUOpE), .func7E(func7E), .func3E(func3E), .WriteAddr_E(WriteAddr_E),
        .ForwardA(ForwardA), .ForwardB(ForwardB),
        .mdu_busy(mdu_busy),
        .RegWriteM(RegWriteM), .MemReadM(MemReadM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
        .BranchM(BranchM), .BNEM(BNEM), .JMPM(JMPM), .ZeroM(ZeroM),
        .WriteAddr_M(WriteAddr_M), .ALUResultM(ALUResultM),
        .ReadData2_M(ReadData2_M), .PCTargetM(PCTargetM)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] fwd_ref(input logic [1:0] sel, input logic [31:0] r, input logic [31:0] w, input logic [31:0] m);
        case (sel)
            2'b00:   return r;
            2'b01:   return w;
            2'b10:   return m;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] alu_ref(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                                            input logic [31:0] a, input logic [31:0] b);
        if (op == 2'b00) return a + b;
        if (op == 2'b01) return a - b;
        if (f7 == 7'h00) begin
            if (f3 == 3'd0) return a + b;
            if (f3 == 3'd7) return a & b;
            if (f3 == 3'd6) return a | b;
            if (f3 == 3'd2) return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            return 32'd0;
        end
        if (f7 == 7'h20 && f3 == 3'd0) return a - b;
        return 32'd0;
    endfunction

    // RV32M semantics using 64-bit arithmetic
    function automatic logic [31:0] mdu_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    function automatic logic [31:0] mop_expect(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && !DIV_EN) return 32'd0;
        return mdu_ref(f3, a, b);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctrl(input logic [6:0] c);
        {RegWriteE, MemReadE, MemWriteE, MemtoRegE, BranchE, BNEE, JMPE} = c;
    endtask

    // ---------------- M-op scenario ----------------
    // smode: 0 plain, 1 stall pulse during RUN, 2 stall in DONE
    task automatic run_mop(input string nm, input logic [2:0] f3, input logic [1:0] fa,
                           input logic [31:0] rd1, input logic [31:0] rd2,
                           input logic [31:0] expv, input int smode);
        logic       iter;
        int         cyc;
        logic [6:0] bub;
        logic [4:0] wa;
        iter = (f3[2] == 1'b0) || DIV_EN;
        wa = 5'($urandom_range(1, 31));
        ALUOpE = 2'b10; func7E = 7'b0000001; func3E = f3;
        ReadData1_E = rd1; ReadData2_E = rd2; ForwardA = fa; ForwardB = 2'b00;
        ALUSrcE = 1'($urandom); ImmOut_E = $urandom; PCE = $urandom; ResultW = $urandom;
        set_ctrl(7'b1000000); WriteAddr_E = wa; stall = 1'b0;
        #1;
        total++;
        if (mdu_busy !== iter) begin
            bad++;
            $display("FAIL %s issue_busy got=%b want=%b", nm, mdu_busy, iter);
        end
        if (iter) begin
            cyc = 0;
            bub = '0;
            while (mdu_busy === 1'b1 && cyc < 200) begin
                cyc++;
                tick();
                bub |= ctrl_out;
                ReadData1_E = $urandom; ReadData2_E = $urandom; ResultW = $urandom;
                stall = (smode == 1) && (cyc >= 5) && (cyc < 10);
                #1;
            end
            total++;
            if (bub !== 7'd0) begin
                bad++;
                $display("FAIL %s bubble_ctrl got=%b want=0000000", nm, bub);
            end
            total++;
            if (cyc !== XLEN + 1) begin
                bad++;
                $display("FAIL %s busy_cycles got=%0d want=%0d", nm, cyc, XLEN + 1);
            end
            stall = (smode == 2);
            #1;
            total++;
            if (mdu_busy !== 1'b0) begin
                bad++;
                $display("FAIL %s done_busy got=%b want=0", nm, mdu_busy);
            end
        end
        tick();
        stall = 1'b0;
        if (smode == 2) begin
            total++;
            if (ctrl_out !== 7'd0) begin
                bad++;
                $display("FAIL %s squash_ctrl got=%b want=0000000", nm, ctrl_out);
            end
            $display("mop %s f3=%0d squashed ctrl=%b", nm, f3, ctrl_out);
        end else begin
            total++;
            if (ALUResultM !== expv) begin
                bad++;
                $display("FAIL %s result got=%h want=%h", nm, ALUResultM, expv);
            end
            total++;
            if (ctrl_out !== 7'b1000000 || WriteAddr_M !== wa || ZeroM !== (expv == 0)) begin
                bad++;
                $display("FAIL %s ex_mem got ctrl=%b wa=%0d z=%b want ctrl=1000000 wa=%0d z=%b",
                         nm, ctrl_out, WriteAddr_M, ZeroM, wa, (expv == 0));
            end
            exp_m = expv;
            $display("mop %s f3=%0d res=%h exp=%h", nm, f3, ALUResultM, expv);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        ALUOpE = 2'b10; func7E = 7'b0000001; func3E = 3'd0;   // M-op present during reset
        set_ctrl(7'h7F); ReadData1_E = 32'd9; ReadData2_E = 32'd9;
        #2;
        total++;
        if (mdu_busy !== 1'b0 || ctrl_out !== 7'd0 || ZeroM !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl got busy=%b ctrl=%b z=%b want 0", mdu_busy, ctrl_out, ZeroM);
        end
        tick();
        total++;
        if (ALUResultM !== 0 || ReadData2_M !== 0 || PCTargetM !== 0 || WriteAddr_M !== 0) begin
            bad++;
            $display("FAIL reset_data got res=%h rd2=%h pct=%h wa=%0d want 0",
                     ALUResultM, ReadData2_M, PCTargetM, WriteAddr_M);
        end
        $display("reset checked");
        ALUOpE = 2'b00; func7E = '0; set_ctrl(7'd0);
        rst = 1'b1;
        exp_m = '0;
    endtask

    task automatic test_alu_random();
        logic [15:0] ops [9];
        logic [15:0] o;
        logic [31:0] a, b, bop, res, rd1, rd2, rw, imm, pc;
        logic [1:0]  fa, fb;
        logic        src;
        logic [6:0]  c;
        ops[0] = {2'b00, 7'h00, 3'd0, 4'd0};
        ops[1] = {2'b01, 7'h00, 3'd0, 4'd0};
        ops[2] = {2'b10, 7'h00, 3'd0, 4'd0};
        ops[3] = {2'b11, 7'h00, 3'd7, 4'd0};
        ops[4] = {2'b10, 7'h00, 3'd6, 4'd0};
        ops[5] = {2'b11, 7'h00, 3'd2, 4'd0};
        ops[6] = {2'b10, 7'h20, 3'd0, 4'd0};
        ops[7] = {2'b10, 7'h00, 3'd1, 4'd0};   // undefined -> 0
        ops[8] = {2'b11, 7'h01, 3'd0, 4'd0};   // M func7 with ALUOp 11 -> 0
        for (int i = 0; i < 24; i++) begin
            o = ops[$urandom_range(0, 8)];
            ALUOpE = o[15:14]; func7E = o[13:7]; func3E = o[6:4];
            if (ALUOpE[1] == 1'b0) begin
                func7E = 7'($urandom); func3E = 3'($urandom);
            end
            rd1 = $urandom; rd2 = (($urandom & 3) == 0) ? rd1 : $urandom;
            rw = $urandom; imm = $urandom; pc = $urandom;
            fa = 2'($urandom); fb = 2'($urandom); src = 1'($urandom);
            if (ALUOpE == 2'b01 && ($urandom & 1)) begin
                fa = 2'b00; fb = 2'b00; src = 1'b0; rd2 = rd1;   // force a zero result
            end
            c = 7'($urandom);
            ReadData1_E = rd1; ReadData2_E = rd2; ResultW = rw; ImmOut_E = imm; PCE = pc;
            ForwardA = fa; ForwardB = fb; ALUSrcE = src; set_ctrl(c);
            WriteAddr_E = 5'(i); stall = 1'b0;
            a = fwd_ref(fa, rd1, rw, exp_m);
            b = fwd_ref(fb, rd2, rw, exp_m);
            bop = src ? imm : b;
            res = alu_ref(ALUOpE, func7E, func3E, a, bop);
            #1;
            total++;
            if (mdu_busy !== 1'b0) begin
                bad++;
                $display("FAIL alu%0d busy got=%b want=0", i, mdu_busy);
            end
            tick();
            total++;
            if (ALUResultM !== res || ZeroM !== (res == 0)) begin
                bad++;
                $display("FAIL alu%0d result got=%h z=%b want=%h z=%b", i, ALUResultM, ZeroM, res, (res == 0));
            end
            total++;
            if (ctrl_out !== c || ReadData2_M !== b || PCTargetM !== pc + imm || WriteAddr_M !== 5'(i)) begin
                bad++;
                $display("FAIL alu%0d pass got ctrl=%b rd2=%h pct=%h want ctrl=%b rd2=%h pct=%h",
                         i, ctrl_out, ReadData2_M, PCTargetM, c, b, pc + imm);
            end
            exp_m = res;
            $display("alu op=%b f7=%h f3=%0d a=%h b=%h res=%h", ALUOpE, func7E, func3E, a, bop, ALUResultM);
        end
    endtask

    task automatic test_mul();
        logic [31:0] a, b;
        logic [2:0]  f;
        run_mop("mul_ff_2",   3'd0, 2'b00, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 0);
        run_mop("mulh_ff_2",  3'd1, 2'b00, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 0);
        run_mop("mulhu_ff_2", 3'd3, 2'b00, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 0);
        for (int i = 0; i < 6; i++) begin
            a = $urandom; b = $urandom; f = 3'($urandom_range(0, 3));
            run_mop("mul_rand", f, 2'b00, a, b, mdu_ref(f, a, b), 0);
        end
    endtask

    task automatic test_div();
        logic [31:0] a, b;
        logic [2:0]  f;
        if (DIV_EN) begin
            run_mop("div_m7_2",   3'd4, 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
            run_mop("rem_m7_2",   3'd6, 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
            run_mop("divu_7_0",   3'd5, 2'b00, 32'd7, 32'd0, 32'hFFFF_FFFF, 0);
            run_mop("remu_7_0",   3'd7, 2'b00, 32'd7, 32'd0, 32'd7, 0);
            run_mop("div_m9_0",   3'd4, 2'b00, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFFF, 0);
            run_mop("rem_m9_0",   3'd6, 2'b00, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 0);
            run_mop("div_ovf",    3'd4, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
            run_mop("rem_ovf",    3'd6, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
            for (int i = 0; i < 6; i++) begin
                a = $urandom; b = $urandom >> $urandom_range(0, 31);
                f = 3'($urandom_range(4, 7));
                run_mop("div_rand", f, 2'b00, a, b, mdu_ref(f, a, b), 0);
            end
        end else begin
            run_mop("div_10_2_nodiv", 3'd4, 2'b00, 32'd10, 32'd2, 32'd0, 0);
            for (int i = 0; i < 4; i++) begin
                a = $urandom; b = $urandom;
                f = 3'($urandom_range(4, 7));
                run_mop("div_rand_nodiv", f, 2'b00, a, b, mop_expect(f, a, b), 0);
            end
        end
    endtask

    task automatic test_forward_capture();
        ALUOpE = 2'b00; func7E = '0; func3E = '0;
        ReadData1_E = 32'd2; ReadData2_E = 32'd3; ForwardA = 2'b00; ForwardB = 2'b00;
        ALUSrcE = 1'b0; set_ctrl(7'b1000000); stall = 1'b0;
        tick();
        total++;
        if (ALUResultM !== 32'd5) begin
            bad++;
            $display("FAIL fwd_setup got=%h want=00000005", ALUResultM);
        end
        exp_m = 32'd5;
        // A comes from ALUResultM (5) at issue; ALUResultM changes during RUN
        run_mop("mul_fwd_m", 3'd0, 2'b10, 32'hDEAD_BEEF, 32'd7, 32'd35, 0);
    endtask

    task automatic test_stall();
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        run_mop("mulhsu_stall_run", 3'd2, 2'b00, a, b, mdu_ref(3'd2, a, b), 1);
        run_mop("mul_stall_done", 3'd0, 2'b00, 32'd6, 32'd7, 32'd42, 2);
        // MDU must be back in IDLE: a plain ADD completes in one cycle
        ALUOpE = 2'b00; func7E = '0; func3E = '0;
        ReadData1_E = 32'd100; ReadData2_E = 32'd23; ForwardA = 2'b00; ForwardB = 2'b00;
        ALUSrcE = 1'b0; set_ctrl(7'b1000000); stall = 1'b0;
        #1;
        total++;
        if (mdu_busy !== 1'b0) begin
            bad++;
            $display("FAIL post_squash_busy got=%b want=0", mdu_busy);
        end
        tick();
        total++;
        if (ALUResultM !== 32'd123 || RegWriteM !== 1'b1) begin
            bad++;
            $display("FAIL post_squash_add got=%h rw=%b want=0000007b rw=1", ALUResultM, RegWriteM);
        end
        exp_m = 32'd123;
        $display("add after squash res=%h", ALUResultM);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        run_mop("b2b_first", 3'd3, 2'b00, a, b, mdu_ref(3'd3, a, b), 0);
        run_mop("b2b_second", 3'd0, 2'b00, b, a, mdu_ref(3'd0, b, a), 0);
    endtask

    task automatic test_reset_mid_run();
        ALUOpE = 2'b10; func7E = 7'b0000001; func3E = 3'd0;
        ReadData1_E = 32'd1234; ReadData2_E = 32'd5678; ForwardA = 2'b00; ForwardB = 2'b00;
        set_ctrl(7'b1000000); stall = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b0;
        #1;
        total++;
        if (mdu_busy !== 1'b0 || ctrl_out !== 7'd0 || ZeroM !== 1'b0 || ALUResultM !== 0 ||
            ReadData2_M !== 0 || PCTargetM !== 0 || WriteAddr_M !== 0) begin
            bad++;
            $display("FAIL midrun_reset got busy=%b ctrl=%b res=%h want all 0", mdu_busy, ctrl_out, ALUResultM);
        end
        #2;
        rst = 1'b1;
        ALUOpE = 2'b00; func7E = '0; func3E = '0;
        ReadData1_E = 32'd3; ReadData2_E = 32'd4; ALUSrcE = 1'b0;
        #1;
        total++;
        if (mdu_busy !== 1'b0) begin
            bad++;
            $display("FAIL after_reset_busy got=%b want=0", mdu_busy);
        end
        tick();
        total++;
        if (ALUResultM !== 32'd7 || RegWriteM !== 1'b1) begin
            bad++;
            $display("FAIL after_reset_add got=%h rw=%b want=00000007 rw=1", ALUResultM, RegWriteM);
        end
        exp_m = 32'd7;
        $display("reset mid-run then add res=%h", ALUResultM);
    endtask

    initial begin
        test_reset();
        test_alu_random();
        test_mul();
        test_div();
        test_forward_capture();
        test_stall();
        test_back_to_back();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
